// File: rtl/mux_response_checker_if.sv
// Signal bundle between the MUX test-bench stimulus/DUT pins and the response checker.
interface mux_response_checker_if;
   logic        enable;
   logic        EN;
   logic        A2;
   logic        A1;
   logic        A0;
   logic        D;
   logic        Y;
   logic [7:0]  pass;
   logic [7:0]  fail;
   logic [15:0] err_cnt;
   logic        busy;
   logic        done;

   modport master (
      output enable, EN, A2, A1, A0, D, Y,
      input  pass, fail, err_cnt, busy, done
   );

   modport slave (
      input  enable, EN, A2, A1, A0, D, Y,
      output pass, fail, err_cnt, busy, done
   );
endinterface

// File: rtl/mux_response_checker.sv
// Response checker for the 8:1 MUX bench: compares synchronized Y against the expected
// level and accumulates per-channel pass/fail flags and a saturating error count.
//
// state | meaning
// IDLE  | waiting for enable, results held
// RUN   | comparing every unmasked cycle, counting 7->0 address wraps
// DONE  | NUM_FRAMES sweeps seen, results frozen until enable drops
module mux_response_checker #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE        = 1,
   parameter int NUM_FRAMES    = 4,
   parameter bit EN_ACTIVE_LOW = 1'b0
) (
   input logic                   clk,
   input logic                   rst,
   mux_response_checker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] SETTLE_L   = 3'(SETTLE);
   localparam logic [7:0] LAST_FRAME = 8'(NUM_FRAMES - 1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] y_sync;
   logic [4:0]             vec_pipe [SYNC_STAGES];
   logic [4:0]             prev_vec;
   logic [4:0]             dvec;
   logic [2:0]             d_a;
   logic [2:0]             settle_cnt;
   logic [2:0]             cnt_eff;
   logic [7:0]             checked;
   logic [7:0]             fail_r;
   logic [7:0]             frame_cnt;
   logic [15:0]            err_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   ys;
   logic                   changed;
   logic                   valid;
   logic                   exp_y;
   logic                   mismatch;
   logic                   wrap;

   // Y and {EN,A,D} travel through equal-depth pipes so ys lines up with dvec
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_sync   <= '0;
         prev_vec <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) vec_pipe[i] <= '0;
      end else begin
         y_sync[0]   <= bus.Y;
         vec_pipe[0] <= {bus.EN, bus.A2, bus.A1, bus.A0, bus.D};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            y_sync[i]   <= y_sync[i-1];
            vec_pipe[i] <= vec_pipe[i-1];
         end
         prev_vec <= dvec;
      end
   end

   assign ys       = y_sync[SYNC_STAGES-1];
   assign dvec     = vec_pipe[SYNC_STAGES-1];
   assign d_a      = dvec[3:1];
   assign changed  = (dvec != prev_vec);
   // the change cycle itself is masked unless SETTLE is 0
   assign cnt_eff  = changed ? SETTLE_L : settle_cnt;
   assign valid    = (cnt_eff == 3'd0);
   assign exp_y    = (dvec[4] ^ EN_ACTIVE_LOW) & dvec[0];
   assign mismatch = (ys != exp_y);
   assign wrap     = (prev_vec[3:1] == 3'd7) && (d_a == 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         checked    <= '0;
         fail_r     <= '0;
         err_r      <= '0;
         frame_cnt  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         if (cnt_eff != 3'd0) settle_cnt <= cnt_eff - 3'd1;
         else                 settle_cnt <= 3'd0;

         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state      <= RUN;
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
                  checked    <= '0;
                  fail_r     <= '0;
                  err_r      <= '0;
                  frame_cnt  <= '0;
                  settle_cnt <= SETTLE_L;
               end
            end
            RUN: begin
               if (!bus.enable) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  if (valid) begin
                     checked[d_a] <= 1'b1;
                     if (mismatch) begin
                        fail_r[d_a] <= 1'b1;
                        if (err_r != 16'hFFFF) err_r <= err_r + 16'd1;
                     end
                  end
                  if (wrap) begin
                     frame_cnt <= frame_cnt + 8'd1;
                     if (frame_cnt == LAST_FRAME) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (!bus.enable) begin
                  state  <= IDLE;
                  done_r <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pass    = checked & ~fail_r;
   assign bus.fail    = fail_r;
   assign bus.err_cnt = err_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_mux_response_checker.sv
// Self-checking bench for mux_response_checker: table of sweep scenarios with a queue of
// expected results, plus hand sequences for latency, enable drop, async reset and saturation.
module tb_mux_response_checker;
   localparam int SYNC_STAGES = 2;
   localparam int SETTLE      = 1;
   localparam int NUM_FRAMES  = 4;
   localparam bit EAL         = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   mux_response_checker_if bus();

   mux_response_checker #(
      .SYNC_STAGES  (SYNC_STAGES),
      .SETTLE       (SETTLE),
      .NUM_FRAMES   (NUM_FRAMES),
      .EN_ACTIVE_LOW(EAL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          en_pin;
      int          y_mode;   // 0 ideal DUT, 1 Y stuck 0, 2 Y high only on channel 3
      int          n_ch;
      int          n_sweeps;
      bit          d_rand;
      logic [7:0]  exp_pass;
      logic [7:0]  exp_fail;
      logic [15:0] exp_err;
      bit          exp_done;
   } scen_t;

   scen_t tbl [4];
   scen_t exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit en_pin, input int a, input bit d, input int y_mode);
      logic [2:0] av;
      av = 3'(a);
      bus.EN = en_pin;
      {bus.A2, bus.A1, bus.A0} = av;
      bus.D = d;
      case (y_mode)
         0:       bus.Y = (en_pin ^ EAL) & d;
         1:       bus.Y = 1'b0;
         default: bus.Y = (av == 3'd3);
      endcase
   endtask

   task automatic slot(input bit en_pin, input int a, input bit d, input int y_mode, input int n);
      drive(en_pin, a, d, y_mode);
      repeat (n) tick();
   endtask

   task automatic run_scen(input scen_t s);
      scen_t e;
      bit    d;
      exp_q.push_back(s);
      bus.enable = 1'b0;
      drive(s.en_pin, 0, 1'b0, s.y_mode);
      repeat (6) tick();
      bus.enable = 1'b1;
      for (int sw = 0; sw < s.n_sweeps; sw++) begin
         for (int ch = 0; ch < s.n_ch; ch++) begin
            d = s.d_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            slot(s.en_pin, ch, d, s.y_mode, 4);
         end
      end
      drive(s.en_pin, 0, 1'b0, s.y_mode);
      for (int i = 0; i < 12 && !bus.done; i++) tick();
      e = exp_q.pop_front();
      chk({e.name, ".done"}, 32'(bus.done), 32'(e.exp_done));
      chk({e.name, ".busy"}, 32'(bus.busy), 32'(!e.exp_done));
      chk({e.name, ".pass"}, 32'(bus.pass), 32'(e.exp_pass));
      chk({e.name, ".fail"}, 32'(bus.fail), 32'(e.exp_fail));
      chk({e.name, ".err"},  32'(bus.err_cnt), 32'(e.exp_err));
      bus.enable = 1'b0;
      tick();
      chk({e.name, ".idle_done"}, 32'(bus.done), 32'd0);
      chk({e.name, ".idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      // 4 cycles per slot, SETTLE=1 -> 3 valid compares per slot
      tbl[0] = '{"ideal",   1'b1, 0, 8, 4, 1'b1, 8'hFF, 8'h00, 16'd0,  1'b1};
      tbl[1] = '{"stuck0",  1'b1, 1, 8, 4, 1'b0, 8'h00, 8'hFF, 16'd96, 1'b1};
      tbl[2] = '{"dis_ch3", 1'b0, 2, 8, 4, 1'b0, 8'hF7, 8'h08, 16'd12, 1'b1};
      tbl[3] = '{"ch0to5",  1'b1, 0, 6, 4, 1'b1, 8'h3F, 8'h00, 16'd0,  1'b0};

      bus.enable = 1'b0;
      drive(1'b1, 0, 1'b0, 0);
      #12;
      chk("rst.pass", 32'(bus.pass), 32'd0);
      chk("rst.fail", 32'(bus.fail), 32'd0);
      chk("rst.err",  32'(bus.err_cnt), 32'd0);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle.busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 4; i++) run_scen(tbl[i]);

      // Y fault reaches err_cnt SYNC_STAGES+1 edges after it is applied
      drive(1'b1, 2, 1'b1, 0);
      repeat (6) tick();
      bus.enable = 1'b1;
      repeat (6) tick();
      chk("lat.pre", 32'(bus.err_cnt), 32'd0);
      bus.Y = 1'b0;
      tick();
      bus.Y = 1'b1;
      chk("lat.e1", 32'(bus.err_cnt), 32'd0);
      tick();
      chk("lat.e2", 32'(bus.err_cnt), 32'd0);
      tick();
      chk("lat.e3", 32'(bus.err_cnt), 32'd1);
      chk("lat.fail", 32'(bus.fail), 32'h04);
      bus.enable = 1'b0;
      tick();

      // enable dropped in frame 2: 10 full slots of errors = 30, then held
      drive(1'b1, 0, 1'b0, 1);
      repeat (6) tick();
      bus.enable = 1'b1;
      for (int ch = 0; ch < 8; ch++) slot(1'b1, ch, 1'b1, 1, 4);
      slot(1'b1, 0, 1'b1, 1, 4);
      slot(1'b1, 1, 1'b1, 1, 4);
      slot(1'b1, 1, 1'b0, 1, 6);
      bus.enable = 1'b0;
      tick();
      chk("drop.busy", 32'(bus.busy), 32'd0);
      chk("drop.done", 32'(bus.done), 32'd0);
      chk("drop.err",  32'(bus.err_cnt), 32'd30);
      chk("drop.fail", 32'(bus.fail), 32'hFF);
      drive(1'b1, 4, 1'b1, 1);
      repeat (5) tick();
      chk("hold.err", 32'(bus.err_cnt), 32'd30);
      bus.enable = 1'b1;
      tick();
      chk("restart.busy", 32'(bus.busy), 32'd1);
      chk("restart.err",  32'(bus.err_cnt), 32'd0);
      chk("restart.fail", 32'(bus.fail), 32'd0);
      bus.enable = 1'b0;
      tick();
      run_scen(tbl[0]);

      // async reset in RUN with err_cnt = 3 + 2
      drive(1'b1, 0, 1'b0, 1);
      repeat (6) tick();
      bus.enable = 1'b1;
      slot(1'b1, 0, 1'b1, 1, 4);
      slot(1'b1, 1, 1'b1, 1, 3);
      slot(1'b1, 1, 1'b0, 1, 5);
      chk("prerst.err",  32'(bus.err_cnt), 32'd5);
      chk("prerst.busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst.err",  32'(bus.err_cnt), 32'd0);
      chk("arst.fail", 32'(bus.fail), 32'd0);
      chk("arst.pass", 32'(bus.pass), 32'd0);
      chk("arst.busy", 32'(bus.busy), 32'd0);
      #2;
      rst = 1'b0;
      tick();
      chk("rerun.busy", 32'(bus.busy), 32'd1);

      // saturation: one mismatch per cycle on channel 1
      drive(1'b1, 1, 1'b1, 1);
      for (int i = 0; i < 70010; i++) tick();
      chk("sat.err",  32'(bus.err_cnt), 32'hFFFF);
      chk("sat.fail", 32'(bus.fail), 32'h02);
      chk("sat.busy", 32'(bus.busy), 32'd1);
      bus.enable = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mux_response_checker.md
Name: mux_response_checker

Overview:
- Response-side companion to the 8:1 MUX stimulus sequencer on the IC test bench.
- Watches the select/enable pattern driven onto the DUT (EN, A2..A0) and the level on the selected data input (D), then samples the DUT output Y through a synchronizer.
- Compares Y against the expected value for every non-masked cycle and accumulates per-channel pass/fail flags and a saturating error count.
- Signals done after a programmed number of complete address sweeps.

Parameters:
- SYNC_STAGES, 2: flops on Y; the expected-value pipeline has the same depth.
- SETTLE, 1: cycles masked after any change of delayed {EN,A,D}; range 0..7.
- NUM_FRAMES, 4: complete address sweeps required before done; range 1..255.
- EN_ACTIVE_LOW, 0: 0 means EN=1 enables the DUT; 1 means EN=0 enables it.

Ports:
- clk  input  1  bench clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  high runs the checker; low idles it.
- EN  input  1  DUT enable pin as driven.
- A2  input  1  DUT select bit 2.
- A1  input  1  DUT select bit 1.
- A0  input  1  DUT select bit 0.
- D  input  1  level currently driven on the selected DUT data input.
- Y  input  1  DUT output, asynchronous to clk.
- pass  output  8  pass[ch] = checked[ch] & ~fail[ch].
- fail  output  8  sticky mismatch flag per channel.
- err_cnt  output  16  total mismatches, saturating at 16'hFFFF.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; pass, fail, checked, err_cnt, frame count, settle counter, both pipelines all 0; busy=0, done=0.
- Y path: Y passes through SYNC_STAGES flops to give ys.
- Expected path: {EN,A2,A1,A0,D} passes through a SYNC_STAGES-deep pipeline to give dEN, dA[2:0], dD. ys and the delayed values are cycle-aligned.
- Expected value: exp = dD when the DUT is enabled (dEN XOR EN_ACTIVE_LOW = 1); otherwise exp = 0.
- Masking: any change of {dEN,dA,dD} versus the previous cycle loads the settle counter with SETTLE. A compare is valid only when the counter is 0 (it decrements to 0). With SETTLE=0, nothing is masked.
- State machine:
  - IDLE: busy=0, done=0, results held.
  - IDLE -> RUN on enable=1. Entry clears pass, fail, checked, err_cnt and frame count, and loads the settle counter with SETTLE.
  - RUN: on each valid compare, set checked[dA]. If ys != exp, set fail[dA] and increment err_cnt (saturating).
  - Frame boundary: dA changes from 7 to 0; frame count increments.
  - RUN -> DONE when the frame count reaches NUM_FRAMES. The compare in the transition cycle is still applied.
  - DONE: results frozen; done=1; no compares.
  - DONE -> IDLE on enable=0.
  - RUN -> IDLE on enable=0: results held, done stays 0.
  - If enable falls in the same cycle the last frame completes, IDLE wins and done is never asserted.
- Disabled-DUT compares (exp=0) are attributed to channel dA.
- Channels never visited keep checked=0, so their pass bit is 0.
- Address wrap: only the 7->0 transition counts as a frame boundary. Other backward jumps (e.g. 5->2) are compared normally but are not frames.
- Latency: a Y fault is reflected in fail/err_cnt SYNC_STAGES+1 cycles after it appears at the Y pin.
- rst asserted mid-RUN: immediate clear to reset values regardless of enable. After rst releases, enable=1 re-enters RUN on the next edge.

Test Plan:
- Ideal DUT model (Y=D when enabled, else 0), A sweeping 0..7 four cycles each, EN enabled throughout, enable=1 -> done=1 after 4 frames; pass=8'hFF, fail=0, err_cnt=0.
- Same stimulus with Y stuck at 0 and D=1 in all slots -> fail=8'hFF, pass=0. err_cnt = 8 ch × 4 frames × (4 − SETTLE) = 96 with SETTLE=1.
- Enable inactive, D=1, Y=1 only on channel 3 -> fail=8'h08; err_cnt=12 with SETTLE=1 (3 valid cycles × 4 frames).
- Sweep only channels 0..5, never 7->0 -> done stays 0; pass=8'h3F; checked[7:6]=0.
- Drop enable in frame 2 -> busy=0, done=0, results held. Re-raise enable -> counters cleared and the run restarts.
- Assert rst during RUN with err_cnt=5 -> all outputs 0 within the same cycle (async). Saturation: force 70000 mismatches -> err_cnt=16'hFFFF.
